// File: rtl/lut_pkg.sv
// Shared LUT types: arbiter FSM states, default segment address width and
// the 16-bit signed LUT data word. Used by the read arbiter, the LUT config
// FSM and the LUT core.
package lut_pkg;

  localparam int LUT_SEG_BITS = 8;

  typedef logic signed [15:0] lut_word_t;

  typedef enum logic [1:0] {
    ST_BLOCK = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } lut_arb_state_t;

  // Width of an index into n items, never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lut_rd_arb_rr_pick.sv
// Round-robin picker: returns a one-hot grant for the first active request
// found when scanning upward (with wrap) from the priority pointer.
module rr_pick
  import lut_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic             found;
  logic [IDX_W-1:0] pos;

  // Scan from the pointer and grant the first requester that is asking.
  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[pos]) begin
        grant[pos] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lut_rd_arb.sv
// LUT read arbiter: grants one of NUM_REQ requesters per cycle in round-robin
// order, forwards the read to the LUT core, tracks the granted index through
// an RD_LAT-deep tag pipeline and returns the core data one cycle after it
// appears. A small FSM blocks new reads while the LUT is being configured and
// drains outstanding reads before reporting the LUT as quiescent (conf_ok).
// Optional statistics counters are enabled by defining LUT_RD_ARB_STATS_EN.
module lut_rd_arb
  import lut_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int SEG_BITS = LUT_SEG_BITS,
  parameter int RD_LAT   = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             conf_mode,
  input  logic                             configured,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0][SEG_BITS-1:0] req_addr,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             lut_rd_en,
  output logic [SEG_BITS-1:0]              lut_rd_addr,
  input  lut_word_t                        lut_rd_base,
  input  lut_word_t                        lut_rd_slope,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output lut_word_t                        rsp_base,
  output lut_word_t                        rsp_slope,
  output logic                             conf_ok,
`ifdef LUT_RD_ARB_STATS_EN
  output logic [1:0]                       state_dbg,
  output logic [NUM_REQ-1:0][31:0]         grant_cnt,
  output logic [31:0]                      block_cnt
`else
  output logic [1:0]                       state_dbg
`endif
);

  localparam int IDX_W = idx_width(NUM_REQ);

  lut_arb_state_t                state;
  lut_arb_state_t                state_next;
  logic [IDX_W-1:0]              ptr;
  logic [NUM_REQ-1:0]            grant;
  logic [IDX_W-1:0]              grant_idx;
  logic                          grant_ok;
  logic                          transfer;
  logic                          in_flight;
  logic [RD_LAT-1:0]             pipe_v;
  logic [RD_LAT-1:0]             pipe_v_next;
  logic [RD_LAT-1:0][IDX_W-1:0]  pipe_tag;

  // conf_mode is checked combinationally so it wins over a same-cycle request.
  assign grant_ok    = (state == ST_RUN) && !conf_mode && configured;
  assign req_ready   = grant_ok ? grant : '0;
  assign transfer    = |(req_ready & req_valid);
  assign lut_rd_en   = transfer;
  assign lut_rd_addr = transfer ? req_addr[grant_idx] : '0;
  assign in_flight   = |pipe_v;
  assign state_dbg   = state;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  // Convert the one-hot grant into the requester index.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx = IDX_W'(i);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_BLOCK;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: run when configured, drain on config request, block once empty.
  always_comb begin
    state_next = state;
    case (state)
      ST_BLOCK: if (configured && !conf_mode) state_next = ST_RUN;
      ST_RUN:   if (conf_mode || !configured) state_next = ST_DRAIN;
      ST_DRAIN: if (!in_flight) state_next = ST_BLOCK;
      default:  state_next = ST_BLOCK;
    endcase
  end

  // Next contents of the valid pipeline, also used to precompute conf_ok.
  always_comb begin
    pipe_v_next    = '0;
    pipe_v_next[0] = transfer;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_v_next[i] = pipe_v[i-1];
    end
  end

  // Round-robin pointer moves past the winner only when a transfer completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (transfer) begin
      ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  // Valid/tag shift pipeline matching the LUT core read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v   <= '0;
      pipe_tag <= '0;
    end else begin
      pipe_v      <= pipe_v_next;
      pipe_tag[0] <= grant_idx;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  // Register the core data and strobe the owning requester one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_base  <= '0;
      rsp_slope <= '0;
    end else begin
      rsp_valid <= '0;
      if (pipe_v[RD_LAT-1]) begin
        rsp_valid <= NUM_REQ'(1) << pipe_tag[RD_LAT-1];
        rsp_base  <= lut_rd_base;
        rsp_slope <= lut_rd_slope;
      end
    end
  end

  // conf_ok reflects blocked state with an empty pipeline in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conf_ok <= 1'b0;
    end else begin
      conf_ok <= (state_next == ST_BLOCK) && !(|pipe_v_next);
    end
  end

`ifdef LUT_RD_ARB_STATS_EN
  // Saturating per-requester grant counters and a blocked-cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
      block_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && req_valid[i] && (grant_cnt[i] != '1)) begin
          grant_cnt[i] <= grant_cnt[i] + 32'd1;
        end
      end
      if ((|req_valid) && !transfer && (block_cnt != '1)) begin
        block_cnt <= block_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lut_rd_arb.sv
// Self-checking bench for lut_rd_arb: a directed vector table, hand-written
// reset and statistics sequences, and randomized traffic checked against a
// queue-based reference model. Statistics checks need LUT_RD_ARB_STATS_EN.
`timescale 1ns/1ps
module tb_lut_rd_arb;
  import lut_pkg::*;

  localparam int NUM_REQ  = 4;
  localparam int SEG_BITS = 8;
  localparam int RD_LAT   = 2;

  logic                             clk = 1'b0;
  logic                             rst = 1'b1;
  logic                             conf_mode = 1'b0;
  logic                             configured = 1'b0;
  logic [NUM_REQ-1:0]               req_valid = '0;
  logic [NUM_REQ-1:0][SEG_BITS-1:0] req_addr = '0;
  logic [NUM_REQ-1:0]               req_ready;
  logic                             lut_rd_en;
  logic [SEG_BITS-1:0]              lut_rd_addr;
  lut_word_t                        lut_rd_base;
  lut_word_t                        lut_rd_slope;
  logic [NUM_REQ-1:0]               rsp_valid;
  lut_word_t                        rsp_base;
  lut_word_t                        rsp_slope;
  logic                             conf_ok;
  logic [1:0]                       state_dbg;
`ifdef LUT_RD_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0]         grant_cnt;
  logic [31:0]                      block_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lut_rd_arb #(
    .NUM_REQ  (NUM_REQ),
    .SEG_BITS (SEG_BITS),
    .RD_LAT   (RD_LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .conf_mode    (conf_mode),
    .configured   (configured),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_ready    (req_ready),
    .lut_rd_en    (lut_rd_en),
    .lut_rd_addr  (lut_rd_addr),
    .lut_rd_base  (lut_rd_base),
    .lut_rd_slope (lut_rd_slope),
    .rsp_valid    (rsp_valid),
    .rsp_base     (rsp_base),
    .rsp_slope    (rsp_slope),
    .conf_ok      (conf_ok),
`ifdef LUT_RD_ARB_STATS_EN
    .state_dbg    (state_dbg),
    .grant_cnt    (grant_cnt),
    .block_cnt    (block_cnt)
`else
    .state_dbg    (state_dbg)
`endif
  );

  // LUT core stand-in: data is a fixed function of the address, valid RD_LAT
  // cycles after the read strobe, and junk at any other time.
  function automatic logic [15:0] core_base(input logic [7:0] a);
    return {a, ~a};
  endfunction

  function automatic logic [15:0] core_slope(input logic [7:0] a);
    return {a ^ 8'h5C, a + 8'd3};
  endfunction

  logic [RD_LAT-1:0]               core_en = '0;
  logic [RD_LAT-1:0][SEG_BITS-1:0] core_addr = '0;

  // Delay the read strobe and address by the core latency.
  always @(posedge clk) begin
    core_en[0]   <= lut_rd_en;
    core_addr[0] <= lut_rd_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      core_en[i]   <= core_en[i-1];
      core_addr[i] <= core_addr[i-1];
    end
  end

  assign lut_rd_base  = core_en[RD_LAT-1] ? core_base(core_addr[RD_LAT-1]) : 16'hDEAD;
  assign lut_rd_slope = core_en[RD_LAT-1] ? core_slope(core_addr[RD_LAT-1]) : 16'h0BAD;

  // Reference model: outstanding reads are a queue of (due cycle, owner, address).
  typedef struct {
    int             due;
    int             tag;
    logic [7:0]     addr;
  } rd_t;

  rd_t          rd_q[$];
  int           m_state;
  int           m_ptr;
  int           m_cycle;
  logic [3:0]   m_rsp_valid;
  logic [15:0]  m_rsp_base;
  logic [15:0]  m_rsp_slope;
  logic         m_conf_ok;

  typedef struct {
    logic       cm;
    logic       cfg;
    logic [3:0] valid;
    logic [3:0] exp_ready;
    logic [1:0] exp_state;
    logic       exp_conf_ok;
    logic [3:0] exp_rsp;
  } vec_t;

  vec_t vecs [24];

  function automatic vec_t mkVec(input logic cm, input logic cfg, input logic [3:0] valid,
                                 input logic [3:0] rdy, input logic [1:0] st,
                                 input logic cok, input logic [3:0] rsp);
    vec_t v;
    v.cm = cm; v.cfg = cfg; v.valid = valid; v.exp_ready = rdy;
    v.exp_state = st; v.exp_conf_ok = cok; v.exp_rsp = rsp;
    return v;
  endfunction

  // Requester the model would grant with the current inputs, or -1.
  function automatic int model_grant();
    if (m_state != 1 || conf_mode || !configured) return -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      int i = (m_ptr + k) % NUM_REQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic cm, input logic cfg, input logic [3:0] valid);
    conf_mode  = cm;
    configured = cfg;
    req_valid  = valid;
  endtask

  task automatic modelReset();
    rd_q.delete();
    m_state     = 0;
    m_ptr       = 0;
    m_cycle     = 0;
    m_rsp_valid = '0;
    m_rsp_base  = '0;
    m_rsp_slope = '0;
    m_conf_ok   = 1'b0;
  endtask

  // Compare every output with the model for this cycle, then advance one clock.
  task automatic runCycle();
    int                 g;
    bit                 busy;
    bit                 later;
    rd_t                e;
    logic [NUM_REQ-1:0] exp_ready;
    #1;
    g = model_grant();
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
    checkOutput("lut_rd_en", 32'(lut_rd_en), (g >= 0) ? 32'd1 : 32'd0);
    checkOutput("lut_rd_addr", 32'(lut_rd_addr), (g >= 0) ? 32'(req_addr[g]) : 32'd0);
    checkOutput("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
    if (m_rsp_valid != '0) begin
      checkOutput("rsp_base", {16'h0, rsp_base}, {16'h0, m_rsp_base});
      checkOutput("rsp_slope", {16'h0, rsp_slope}, {16'h0, m_rsp_slope});
    end
    checkOutput("conf_ok", 32'(conf_ok), 32'(m_conf_ok));
    checkOutput("state_dbg", 32'(state_dbg), 32'(m_state));

    busy = 1'b0;
    foreach (rd_q[j]) if (rd_q[j].due > m_cycle) busy = 1'b1;
    if (g >= 0) begin
      e.due  = m_cycle + RD_LAT + 1;
      e.tag  = g;
      e.addr = req_addr[g];
      rd_q.push_back(e);
      m_ptr = (g + 1) % NUM_REQ;
    end
    case (m_state)
      0: if (configured && !conf_mode) m_state = 1;
      1: if (conf_mode || !configured) m_state = 2;
      default: if (!busy) m_state = 0;
    endcase
    m_rsp_valid = '0;
    later = 1'b0;
    foreach (rd_q[j]) begin
      if (rd_q[j].due == m_cycle + 1) begin
        m_rsp_valid[rd_q[j].tag] = 1'b1;
        m_rsp_base  = core_base(rd_q[j].addr);
        m_rsp_slope = core_slope(rd_q[j].addr);
      end
      if (rd_q[j].due > m_cycle + 1) later = 1'b1;
    end
    m_conf_ok = (m_state == 0) && !later;
    m_cycle++;
    while (rd_q.size() > 0 && rd_q[0].due <= m_cycle) void'(rd_q.pop_front());

    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold reset across a clock edge, check the reset values, then release.
  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'b0000);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_state", 32'(state_dbg), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_base", {16'h0, rsp_base}, 32'd0);
    checkOutput("rst_rsp_slope", {16'h0, rsp_slope}, 32'd0);
    checkOutput("rst_conf_ok", 32'(conf_ok), 32'd0);
    checkOutput("rst_rd_en", 32'(lut_rd_en), 32'd0);
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    logic               cm_r;
    logic               cfg_r;
    logic [NUM_REQ-1:0] held;
    logic [NUM_REQ-1:0] nv;
    int                 g;

    // Rows assume RD_LAT = 2: a grant in row r responds in row r+3.
    vecs[0]  = mkVec(0, 0, 4'b0000, 4'b0000, 2'd0, 0, 4'b0000);
    vecs[1]  = mkVec(0, 0, 4'b1111, 4'b0000, 2'd0, 1, 4'b0000);
    vecs[2]  = mkVec(0, 1, 4'b1111, 4'b0000, 2'd0, 1, 4'b0000);
    vecs[3]  = mkVec(0, 1, 4'b1111, 4'b0001, 2'd1, 0, 4'b0000);
    vecs[4]  = mkVec(0, 1, 4'b1111, 4'b0010, 2'd1, 0, 4'b0000);
    vecs[5]  = mkVec(0, 1, 4'b1111, 4'b0100, 2'd1, 0, 4'b0000);
    vecs[6]  = mkVec(0, 1, 4'b1111, 4'b1000, 2'd1, 0, 4'b0001);
    vecs[7]  = mkVec(0, 1, 4'b1111, 4'b0001, 2'd1, 0, 4'b0010);
    vecs[8]  = mkVec(0, 1, 4'b1111, 4'b0010, 2'd1, 0, 4'b0100);
    vecs[9]  = mkVec(0, 1, 4'b1111, 4'b0100, 2'd1, 0, 4'b1000);
    vecs[10] = mkVec(0, 1, 4'b1111, 4'b1000, 2'd1, 0, 4'b0001);
    vecs[11] = mkVec(0, 1, 4'b0000, 4'b0000, 2'd1, 0, 4'b0010);
    vecs[12] = mkVec(0, 1, 4'b0100, 4'b0100, 2'd1, 0, 4'b0100);
    vecs[13] = mkVec(0, 1, 4'b0000, 4'b0000, 2'd1, 0, 4'b1000);
    vecs[14] = mkVec(0, 1, 4'b0000, 4'b0000, 2'd1, 0, 4'b0000);
    vecs[15] = mkVec(0, 1, 4'b0000, 4'b0000, 2'd1, 0, 4'b0100);
    vecs[16] = mkVec(0, 1, 4'b1010, 4'b1000, 2'd1, 0, 4'b0000);
    vecs[17] = mkVec(0, 1, 4'b1010, 4'b0010, 2'd1, 0, 4'b0000);
    vecs[18] = mkVec(1, 1, 4'b1010, 4'b0000, 2'd1, 0, 4'b0000);
    vecs[19] = mkVec(1, 1, 4'b1010, 4'b0000, 2'd2, 0, 4'b1000);
    vecs[20] = mkVec(1, 1, 4'b1010, 4'b0000, 2'd2, 0, 4'b0010);
    vecs[21] = mkVec(1, 1, 4'b1010, 4'b0000, 2'd0, 1, 4'b0000);
    vecs[22] = mkVec(0, 1, 4'b0000, 4'b0000, 2'd0, 1, 4'b0000);
    vecs[23] = mkVec(0, 1, 4'b0001, 4'b0001, 2'd1, 0, 4'b0000);

    @(negedge clk);
    resetDut();

    req_addr[0] = 8'h10;
    req_addr[1] = 8'h11;
    req_addr[2] = 8'h2A;
    req_addr[3] = 8'h13;
    for (int r = 0; r < 24; r++) begin
      applyStimulus(vecs[r].cm, vecs[r].cfg, vecs[r].valid);
      #1;
      checkOutput($sformatf("vec%0d_ready", r), 32'(req_ready), 32'(vecs[r].exp_ready));
      checkOutput($sformatf("vec%0d_state", r), 32'(state_dbg), 32'(vecs[r].exp_state));
      checkOutput($sformatf("vec%0d_conf_ok", r), 32'(conf_ok), 32'(vecs[r].exp_conf_ok));
      checkOutput($sformatf("vec%0d_rsp", r), 32'(rsp_valid), 32'(vecs[r].exp_rsp));
      if (r == 12) checkOutput("single_addr", 32'(lut_rd_addr), 32'h2A);
      if (r == 15) checkOutput("single_base", {16'h0, rsp_base}, 32'h2AD5);
      runCycle();
    end

    // Reset one cycle after a grant: the read must vanish and the pointer restart.
    resetDut();
    applyStimulus(1'b0, 1'b1, 4'b0000);
    runCycle();
    applyStimulus(1'b0, 1'b1, 4'b0100);
    runCycle();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, 4'b0000);
    for (int c = 0; c < RD_LAT + 2; c++) begin
      #1;
      checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("midrst_state", 32'(state_dbg), 32'd0);
      @(negedge clk);
    end
    rst = 1'b0;
    modelReset();
    runCycle();
    applyStimulus(1'b0, 1'b1, 4'b1111);
    #1;
    checkOutput("midrst_ptr_zero", 32'(req_ready), 32'b0001);
    runCycle();
    applyStimulus(1'b0, 1'b1, 4'b0000);
    for (int c = 0; c < RD_LAT + 2; c++) runCycle();

    // Randomized traffic; a request that is not granted holds valid and address.
    cm_r  = 1'b0;
    cfg_r = 1'b1;
    held  = '0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 15) == 0) cm_r = ~cm_r;
      if ($urandom_range(0, 31) == 0) cfg_r = ~cfg_r;
      nv = held;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!held[i]) begin
          nv[i]       = 1'($urandom_range(0, 1));
          req_addr[i] = 8'($urandom);
        end
      end
      applyStimulus(cm_r, cfg_r, nv);
      g = model_grant();
      held = nv;
      if (g >= 0) held[g] = 1'b0;
      runCycle();
    end
    applyStimulus(1'b0, 1'b1, 4'b0000);
    for (int c = 0; c < RD_LAT + 3; c++) runCycle();

`ifdef LUT_RD_ARB_STATS_EN
    // Three blocked cycles while unconfigured, then five grants to requester 1.
    resetDut();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 1'b0, 4'b0010);
      runCycle();
    end
    applyStimulus(1'b0, 1'b1, 4'b0000);
    runCycle();
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, 1'b1, 4'b0010);
      runCycle();
    end
    applyStimulus(1'b0, 1'b1, 4'b0000);
    #1;
    checkOutput("grant_cnt1", grant_cnt[1], 32'd5);
    checkOutput("grant_cnt0", grant_cnt[0], 32'd0);
    checkOutput("block_cnt", block_cnt, 32'd3);
    for (int c = 0; c < RD_LAT + 2; c++) runCycle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lut_rd_arb.md
LUT_RD_ARB -- requirements
Module: lut_rd_arb

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 4, number of requesters; SEG_BITS, default 8, LUT address width; RD_LAT, default 1, LUT core read latency in cycles (1..3).
REQ-002 Ports SHALL be, as name  direction  width  meaning:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- conf_mode  in  1  configuration load requested.
- configured  in  1  LUT contents valid.
- req_valid  in  NUM_REQ  per-requester read request.
- req_addr  in  NUM_REQ x SEG_BITS  per-requester segment address.
- req_ready  out  NUM_REQ  one-hot grant; a transfer happens when valid and ready are both high.
- lut_rd_en  out  1  read strobe to the LUT core.
- lut_rd_addr  out  SEG_BITS  read address to the LUT core.
- lut_rd_base  in  16 signed  core base output, RD_LAT cycles after lut_rd_en.
- lut_rd_slope  in  16 signed  core slope output, RD_LAT cycles after lut_rd_en.
- rsp_valid  out  NUM_REQ  one-hot response strobe; requesters cannot stall it.
- rsp_base  out  16 signed  returned base.
- rsp_slope  out  16 signed  returned slope.
- conf_ok  out  1  LUT is quiescent and the config FSM may write.
- state_dbg  out  2  current FSM state.

Function
REQ-003 The FSM SHALL have these states: ST_BLOCK=0, ST_RUN=1, ST_DRAIN=2.
REQ-004 ST_BLOCK SHALL move to ST_RUN when configured=1 and conf_mode=0.
REQ-005 ST_RUN SHALL move to ST_DRAIN when conf_mode=1 or configured=0.
REQ-006 ST_DRAIN SHALL move to ST_BLOCK when no read is in flight.
REQ-007 req_ready SHALL be combinational and SHALL be nonzero only in ST_RUN when conf_mode=0 and configured=1.
REQ-008 At most one requester SHALL be granted per cycle.
REQ-009 Grant SHALL be round-robin: priority starts at the index after the last granted requester, and starts at index 0 after reset.
REQ-010 The round-robin pointer SHALL update only on a completed transfer.
REQ-011 lut_rd_en SHALL be high in exactly the cycle of a transfer, and lut_rd_addr SHALL equal the granted req_addr in that cycle; lut_rd_addr SHALL read 0 otherwise.
REQ-012 The granted requester index SHALL be carried in an RD_LAT-deep valid/tag shift pipeline.
REQ-013 rsp_valid SHALL be the one-hot decode of the tag, asserted exactly RD_LAT+1 cycles after the transfer, with rsp_base and rsp_slope registered from the core outputs.
REQ-014 Responses SHALL return in grant order, one per cycle, giving a sustained throughput of one read per cycle.
REQ-015 conf_ok SHALL be a registered output, high only in ST_BLOCK with the pipeline empty.
REQ-016 If conf_mode and a request rise in the same cycle, conf_mode SHALL win: no grant is issued.
REQ-017 Reads granted before ST_DRAIN SHALL complete and return normally.
REQ-018 A requester holding valid without a grant SHALL keep its address stable, and the block SHALL NOT drop the request.

Reset
REQ-019 While rst is high, and on its deassertion, the block SHALL hold: state=ST_BLOCK, round-robin pointer=0, pipeline valid bits=0, rsp_valid=0, rsp_base=0, rsp_slope=0, conf_ok=0, lut_rd_en=0.
REQ-020 Reset mid-operation SHALL discard all in-flight reads, and no response SHALL be produced for them.

Configuration
REQ-021 With LUT_RD_ARB_STATS_EN defined, the block SHALL add:
- output grant_cnt, NUM_REQ x 32, per-requester saturating transfer counters;
- output block_cnt, 32, saturating count of cycles with any req_valid high but no grant;
- all counters reset to 0.
REQ-022 Without LUT_RD_ARB_STATS_EN, those ports and counters SHALL NOT exist, and all other behaviour SHALL be identical.

Structure
REQ-023 A shared package lut_pkg SHALL hold the lut_arb_state_t enum, the SEG_BITS default and the 16-bit LUT data typedef lut_word_t, shared with the LUT config FSM and the LUT core.
REQ-024 The round-robin picker SHALL be a sub-module rr_pick (inputs: request vector, pointer; output: one-hot grant), instantiated once.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Single request: configured=1, req_valid=4'b0100, addr=0x2A -> req_ready=4'b0100 in the same cycle, lut_rd_addr=0x2A, rsp_valid=4'b0100 RD_LAT+1 cycles later with the core data.
- Fairness: all four requesting for 8 cycles -> grants 0,1,2,3,0,1,2,3 with one rsp per cycle in the same order.
- Not configured: configured=0 with requests pending -> req_ready=0 and lut_rd_en=0 throughout.
- Conf mid-stream: conf_mode=1 while 2 reads are in flight -> no new grants, both responses still delivered, conf_ok=1 one cycle after the last response.
- Reset mid-read: rst pulsed the cycle after a grant -> no rsp_valid, pointer back to 0, state_dbg=0.
- With LUT_RD_ARB_STATS_EN defined: 5 grants to requester 1 and 3 blocked cycles -> grant_cnt[1]=5 and block_cnt=3.
